// File: rtl/acc_buffer.sv
// acc_buffer: per-address row store of MATRIX_WIDTH partial-sum lanes.
// Writes either overwrite a row or add into it through a short
// read-modify-write pipeline. A write captured on the edge ending cycle T
// has its sum formed during T+1 and is committed to the array on the edge
// ending T+1. A back-to-back write to the same row takes the in-flight sum
// instead of the stale array contents, so consecutive accumulates add up
// exactly. An independent registered read port feeds the activation stage.
module acc_buffer #(
  parameter int MATRIX_WIDTH = 4,
  parameter int ACC_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic                              wr_acc,
  input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0] wr_data,
  input  logic                              rd_en,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [MATRIX_WIDTH*ACC_WIDTH-1:0] rd_data,
  output logic                              rd_valid,
  output logic                              busy
);

  localparam int ROW_W = MATRIX_WIDTH * ACC_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Row storage
  logic [ROW_W-1:0] mem [DEPTH];

  // S1: captured write request plus the row it will be added to
  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_acc;
  logic [ROW_W-1:0]      s1_data;
  logic [ROW_W-1:0]      s1_old;

  // S2: the sum stage is combinational over the S1 registers, so it is
  // occupied exactly when S1 holds a write.
  logic                  s2_valid;
  logic [ROW_W-1:0]      s2_result;

  logic [ROW_W-1:0]      old_row;
  logic                  commit;

  assign s2_valid = s1_valid;

  // A freeze or a reset both suppress the commit; under reset the write is
  // discarded for good.
  assign commit = s2_valid && enable && !rst;

  assign busy = s1_valid | s2_valid;

  // Per-lane overwrite or modular add; lanes never carry into each other
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    s2_result = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      if (s1_acc)
        s2_result[i*ACC_WIDTH +: ACC_WIDTH] =
          s1_old[i*ACC_WIDTH +: ACC_WIDTH] + s1_data[i*ACC_WIDTH +: ACC_WIDTH];
      else
        s2_result[i*ACC_WIDTH +: ACC_WIDTH] = s1_data[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Old-row source for a new write: the in-flight sum wins over the array
  // when it targets the same row, since the array update lands on this edge.
  always_comb begin
    old_row = mem[wr_addr];
    if (s2_valid && (s1_addr == wr_addr))
      old_row = s2_result;
  end

  // S1 capture; a freeze holds the stage, a new write replaces a committing one
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_acc   <= 1'b0;
      s1_data  <= '0;
      s1_old   <= '0;
    end else if (enable) begin
      s1_valid <= wr_en;
      if (wr_en) begin
        s1_addr <= wr_addr;
        s1_acc  <= wr_acc;
        s1_data <= wr_data;
        s1_old  <= old_row;
      end
    end
  end

  // Array write port: commit the finished row
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing it would defeat RAM inference
    // and it is always written before being accumulated into.
    if (commit)
      mem[s1_addr] <= s2_result;
  end

  // Registered read port; data holds between reads, no forwarding from writes
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (enable) begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= mem[rd_addr];
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_buffer.sv
// Directed bench for acc_buffer: a vector table for the write/read paths,
// followed by hand-written sequences for the freeze and reset corner cases.
module tb_acc_buffer;

  localparam int MW = 4;
  localparam int AW = 32;
  localparam int RW = MW * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic          wr_acc;
  logic [RW-1:0] wr_data;
  logic          rd_en;
  logic [7:0]    rd_addr;
  logic [RW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          rst;
    logic          en;
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic          wr_acc;
    logic [RW-1:0] wr_data;
    logic          rd_en;
    logic [7:0]    rd_addr;
    logic          exp_valid;
    logic [RW-1:0] exp_data;
    logic          exp_busy;
    string         name;
  } vec_t;

  vec_t vecs[$];

  acc_buffer #(.MATRIX_WIDTH(MW), .ACC_WIDTH(AW), .ADDR_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_acc   (wr_acc),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Lane 0 is the first listed value
  function automatic logic [RW-1:0] row(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [RW-1:0] splat(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic en, input logic we, input logic [7:0] wa,
                     input logic acc, input logic [RW-1:0] wd, input logic re,
                     input logic [7:0] ra, input logic ev, input logic [RW-1:0] ed,
                     input logic eb, input string name);
    vec_t v;
    v.rst = r; v.en = en; v.wr_en = we; v.wr_addr = wa; v.wr_acc = acc;
    v.wr_data = wd; v.rd_en = re; v.rd_addr = ra; v.exp_valid = ev;
    v.exp_data = ed; v.exp_busy = eb; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare outputs
  task automatic apply(input vec_t v);
    rst = v.rst; enable = v.en; wr_en = v.wr_en; wr_addr = v.wr_addr;
    wr_acc = v.wr_acc; wr_data = v.wr_data; rd_en = v.rd_en; rd_addr = v.rd_addr;
    @(posedge clk);
    #1;
    check({v.name, ".rd_valid"}, RW'(rd_valid), RW'(v.exp_valid));
    check({v.name, ".rd_data"},  rd_data,       v.exp_data);
    check({v.name, ".busy"},     RW'(busy),     RW'(v.exp_busy));
  endtask

  initial begin
    logic [RW-1:0] r1234, r_t2;
    r1234 = row(1, 2, 3, 4);
    r_t2  = row(11, 21, 31, 41);

    rst = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_acc = 1'b0;
    wr_data = '0; rd_en = 1'b0; rd_addr = '0;

    //   rst en we addr acc data          re addr  ev data         busy
    add(1, 1, 0, 0,  0, '0,               0, 0,   0, '0,           0, "reset0");
    add(1, 1, 0, 0,  0, '0,               0, 0,   0, '0,           0, "reset1");
    // Test 1: plain write then read
    add(0, 1, 1, 3,  0, r1234,            0, 0,   0, '0,           1, "t1_wr");
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, '0,           0, "t1_idle0");
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, '0,           0, "t1_idle1");
    add(0, 1, 0, 0,  0, '0,               1, 3,   1, r1234,        0, "t1_rd");
    // Test 2: overwrite then forwarded accumulate
    add(0, 1, 1, 5,  0, row(10,20,30,40), 0, 0,   0, r1234,        1, "t2_wr");
    add(0, 1, 1, 5,  1, splat(1),         0, 0,   0, r1234,        1, "t2_acc");
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, r1234,        0, "t2_idle");
    add(0, 1, 0, 0,  0, '0,               1, 5,   1, r_t2,         0, "t2_rd");
    // Test 3: counter pattern, with a concurrent read of row 3 at k=2
    for (int k = 0; k < 8; k++)
      add(0, 1, 1, 8'(11 + k % 4), k >= 4, splat(32'(k)), k == 2, 3, k == 2,
          (k >= 2) ? r1234 : r_t2, 1, $sformatf("t3_wr%0d", k));
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, r1234,        0, "t3_idle");
    add(0, 1, 0, 0,  0, '0,               1, 11,  1, splat(4),     0, "t3_rd11");
    add(0, 1, 0, 0,  0, '0,               1, 12,  1, splat(6),     0, "t3_rd12");
    add(0, 1, 0, 0,  0, '0,               1, 13,  1, splat(8),     0, "t3_rd13");
    add(0, 1, 0, 0,  0, '0,               1, 14,  1, splat(10),    0, "t3_rd14");
    // Test 4: per-lane wrap, busy falls two cycles after the last write
    add(0, 1, 1, 20, 0, splat(32'hFFFF_FFFF), 0, 0, 0, splat(10),  1, "t4_wr");
    add(0, 1, 1, 20, 1, splat(2),         0, 0,   0, splat(10),    1, "t4_acc");
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, splat(10),    0, "t4_idle");
    add(0, 1, 0, 0,  0, '0,               1, 20,  1, splat(1),     0, "t4_rd");
    // Read one cycle after a write sees the old row; two cycles after sees the new
    add(0, 1, 1, 20, 0, splat(9),         0, 0,   0, splat(1),     1, "ord_wr");
    add(0, 1, 0, 0,  0, '0,               1, 20,  1, splat(1),     0, "ord_rd_old");
    add(0, 1, 0, 0,  0, '0,               1, 20,  1, splat(9),     0, "ord_rd_new");

    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    // Test 5: freeze mid-pipeline; requests during the freeze are dropped
    add(0, 1, 1, 7,  0, splat(1),         0, 0,   0, splat(9),     1, "t5_wr");
    add(0, 1, 1, 7,  1, splat(5),         0, 0,   0, splat(9),     1, "t5_acc");
    for (int s = 0; s < 3; s++)
      add(0, 0, 1, 7, 1, splat(100),      1, 7,   0, splat(9),     1, $sformatf("t5_stall%0d", s));
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, splat(9),     0, "t5_resume");
    add(0, 1, 0, 0,  0, '0,               1, 7,   1, splat(6),     0, "t5_rd");
    // Test 6: reset discards the in-flight accumulate
    add(0, 1, 1, 9,  0, splat(7),         0, 0,   0, splat(6),     1, "t6_wr");
    add(0, 1, 1, 9,  1, splat(1),         0, 0,   0, splat(6),     1, "t6_acc");
    add(1, 1, 0, 0,  0, '0,               1, 9,   0, '0,           0, "t6_rst");
    add(0, 1, 0, 0,  0, '0,               0, 0,   0, '0,           0, "t6_idle");
    add(0, 1, 0, 0,  0, '0,               1, 9,   1, splat(7),     0, "t6_rd");

    foreach (vecs[i]) apply(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
